// File: rtl/tile_pattern_gen_if.sv
// Board-generator bus between the game controller (master) and tile_pattern_gen (slave).
// Parameters must match those given to the attached tile_pattern_gen instance.
interface tile_pattern_gen_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int LFSR_W = 16
);
    localparam int CELLS = ROWS * COLS;
    localparam int CNT_W = $clog2(CELLS + 1);

    // Handshake: gen_start is a request sampled only while the generator is idle
    // (busy low); requests seen while busy are dropped, not queued. tile_count is
    // captured on the accepting edge. board_valid is a one-cycle pulse marking the
    // cycle board takes a new value; board then holds until the next such pulse.
    logic             gen_start;
    logic [CNT_W-1:0] tile_count;
    logic             busy;
    logic             board_valid;
    logic [CELLS-1:0] board;
    logic [LFSR_W-1:0] lfsr_state;
    logic [1:0]       state_dbg;

    modport master (
        output gen_start,
        output tile_count,
        input  busy,
        input  board_valid,
        input  board,
        input  lfsr_state,
        input  state_dbg
    );

    modport slave (
        input  gen_start,
        input  tile_count,
        output busy,
        output board_valid,
        output board,
        output lfsr_state,
        output state_dbg
    );
endinterface

// File: rtl/tile_pattern_gen.sv
// ROWS x COLS Memory Matrix board generator: places N distinct lit tiles from a free-running LFSR.
// Optional macro SEED_LOAD_EN adds seed_load/seed ports for repeatable boards.
module tile_pattern_gen #(
    parameter int                ROWS      = 4,
    parameter int                COLS      = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    tile_pattern_gen_if.slave   bus
`ifdef SEED_LOAD_EN
    ,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed
`endif
);
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int CNT_W = $clog2(CELLS + 1);
    localparam logic [CNT_W-1:0] CELLS_CNT = CNT_W'(CELLS);
    localparam logic [IDX_W:0]   CELLS_IDX = (IDX_W + 1)'(CELLS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [CELLS-1:0]  work_q, work_d;
    logic [CELLS-1:0]  board_q, board_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              busy_q, busy_d;
    logic              board_valid_q, board_valid_d;

    logic [IDX_W-1:0]  idx;
    logic              idx_free;
    logic [CNT_W-1:0]  count_clamped;

    assign idx           = lfsr_q[IDX_W-1:0];
    assign idx_free      = ({1'b0, idx} < CELLS_IDX) && !work_q[idx];
    assign count_clamped = (bus.tile_count > CELLS_CNT) ? CELLS_CNT : bus.tile_count;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
`ifdef SEED_LOAD_EN
        // An all-zero seed would lock the LFSR, so it falls back to the reset seed.
        if (seed_load) begin
            lfsr_d = (seed == '0) ? LFSR_SEED : seed;
        end
`endif
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        board_d = board_q;

        case (state_q)
            IDLE: begin
                if (bus.gen_start) begin
                    work_d  = '0;
                    rem_d   = count_clamped;
                    state_d = (count_clamped == '0) ? DONE : PLACE;
                end
            end
            PLACE: begin
                if (idx_free) begin
                    work_d[idx] = 1'b1;
                    rem_d       = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The display only ever sees a complete board, copied on the DONE-entry edge.
        if (state_d == DONE) begin
            board_d = work_d;
        end
        busy_d        = (state_d != IDLE);
        board_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            lfsr_q        <= LFSR_SEED;
            work_q        <= '0;
            rem_q         <= '0;
            board_q       <= '0;
            busy_q        <= 1'b0;
            board_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            work_q        <= work_d;
            rem_q         <= rem_d;
            board_q       <= board_d;
            busy_q        <= busy_d;
            board_valid_q <= board_valid_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.board_valid = board_valid_q;
    assign bus.board       = board_q;
    assign bus.lfsr_state  = lfsr_q;
    assign bus.state_dbg   = state_q;
endmodule
